// File: rtl/mem_stage_lsu_pkg.sv
// mem_stage_lsu_pkg: shared funct3 codes, FSM state encoding and AXI response
// codes for the memory-access stage.
package mem_stage_lsu_pkg;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} state_e;
endpackage

// File: rtl/mem_stage_lsu_data_align.sv
// lsu_data_align: store lane replication/strobes, load lane extraction and
// extension, and illegal-funct3/misalignment detection.
module lsu_data_align
    import mem_stage_lsu_pkg::*;
(
    input  logic        rd,
    input  logic        wr,
    input  logic [2:0]  f3,
    input  logic [1:0]  lo,
    input  logic [31:0] st_in,
    input  logic [31:0] rd_in,
    output logic [31:0] st_data,
    output logic [3:0]  st_strb,
    output logic [31:0] ld_data,
    output logic        err
);
    logic [15:0] sh;
    logic        legal;
    logic        misal;
    always_comb begin
        sh      = 16'(rd_in >> {lo, 3'b000});
        ld_data = f3 == F3_LB  ? {{24{sh[7]}}, sh[7:0]} :
                  f3 == F3_LH  ? {{16{sh[15]}}, sh} :
                  f3 == F3_LBU ? {24'b0, sh[7:0]} :
                  f3 == F3_LHU ? {16'b0, sh} : rd_in;
        st_data = f3 == F3_SB ? {4{st_in[7:0]}} : f3 == F3_SH ? {2{st_in[15:0]}} : st_in;
        st_strb = f3 == F3_SB ? 4'b0001 << lo : f3 == F3_SH ? 4'b0011 << lo : 4'b1111;
        // a load wins when both op bits are set, so it is checked against the load codes
        legal   = rd ? f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU} :
                  wr ? f3 inside {F3_SB, F3_SH, F3_SW} : 1'b1;
        misal   = (rd | wr) && (f3[1:0] == 2'b01 ? lo[0] : f3[1:0] == 2'b10 ? lo != 2'b00 : 1'b0);
        err     = !legal | misal;
    end
endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory-access stage; performs one load/store per instruction
// over AXI4-Lite and offers the extended result to the W stage.
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [ADDR_W-1:0] addrE,
    input  logic [31:0]       wdataE,
    input  logic              memrdE,
    input  logic              memwrE,
    input  logic [2:0]        funct3E,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [31:0]       mdataM,
    output logic              errM,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [31:0]       rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    output logic [ADDR_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [31:0]       wdata,
    output logic [3:0]        wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d, mdata_q, mdata_d, st_data, ld_data;
    logic [2:0]        f3_q, f3_d;
    logic [3:0]        st_strb;
    logic              rd_q, rd_d, wr_q, wr_d, aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic              err_q, err_d, al_err, idle, wr_req;

    assign idle   = state_q == IDLE;
    assign wr_req = state_q == WR_REQ;

    // in IDLE the checker sees the incoming fields so the accept edge can branch on them
    lsu_data_align u_align (
        .rd      (idle ? memrdE : rd_q),
        .wr      (idle ? memwrE : wr_q),
        .f3      (idle ? funct3E : f3_q),
        .lo      (idle ? addrE[1:0] : addr_q[1:0]),
        .st_in   (wdata_q),
        .rd_in   (rdata),
        .st_data (st_data),
        .st_strb (st_strb),
        .ld_data (ld_data),
        .err     (al_err)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        f3_d      = f3_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        mdata_d   = mdata_q;
        err_d     = err_q;
        case (state_q)
            IDLE: if (s_valid) begin
                addr_d  = addrE;
                wdata_d = wdataE;
                rd_d    = memrdE;
                wr_d    = memwrE;
                f3_d    = funct3E;
                err_d   = al_err;
                mdata_d = '0;
                state_d = al_err ? DONE : memrdE ? RD_ADDR : memwrE ? WR_REQ : DONE;
            end
            RD_ADDR: state_d = arready ? RD_DATA : RD_ADDR;
            RD_DATA: if (rvalid) begin
                err_d   = rresp != RESP_OKAY;
                mdata_d = rresp != RESP_OKAY ? '0 : ld_data;
                state_d = DONE;
            end
            WR_REQ: begin
                aw_done_d = aw_done_q | awready;
                w_done_d  = w_done_q | wready;
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = WR_RESP;
                end
            end
            WR_RESP: if (bvalid) begin
                err_d   = bresp != RESP_OKAY;
                mdata_d = '0;
                state_d = DONE;
            end
            DONE: state_d = m_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            f3_q      <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            mdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            f3_q      <= f3_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            mdata_q   <= mdata_d;
            err_q     <= err_d;
        end
    end

    assign s_ready = idle;
    assign m_valid = state_q == DONE;
    assign mdataM  = mdata_q;
    assign errM    = err_q;
    assign araddr  = addr_q;
    assign arvalid = state_q == RD_ADDR;
    assign rready  = state_q == RD_DATA;
    assign awaddr  = addr_q;
    assign awvalid = wr_req && !aw_done_q;
    assign wvalid  = wr_req && !w_done_q;
    assign wdata   = wr_req ? st_data : '0;
    assign wstrb   = wr_req ? st_strb : '0;
    assign bready  = state_q == WR_RESP;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: randomized and directed stimulus against an arithmetic
// reference model, with a delay-programmable AXI4-Lite slave.
module tb_mem_stage_lsu;
    typedef struct packed {
        logic [1:0]  kind;
        logic        err;
        logic [31:0] mdata;
        logic [31:0] wd;
        logic [3:0]  ws;
    } exp_t;

    logic        clk = 1'b0, rst = 1'b1;
    logic        s_valid = 1'b0, s_ready, memrdE = 1'b0, memwrE = 1'b0;
    logic [31:0] addrE = '0, wdataE = '0;
    logic [2:0]  funct3E = '0;
    logic        m_valid, m_ready = 1'b0, errM;
    logic [31:0] mdataM, araddr, awaddr, wdata, rdata = '0;
    logic        arvalid, arready = 1'b0, rvalid = 1'b0, rready;
    logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0, bvalid = 1'b0, bready;
    logic [1:0]  rresp = '0, bresp = '0;
    logic [3:0]  wstrb;

    int checks = 0, errors = 0;
    int ar_dly = 0, aw_dly = 0, w_dly = 0, r_dly = 0, b_dly = 0;
    int ar_cnt = 0, aw_cnt = 0, w_cnt = 0, r_cnt = 0, b_cnt = 0;
    int n_ar = 0, n_r = 0, n_aw = 0, n_w = 0, n_b = 0;
    logic [31:0] cur_rdata = '0, cur_addr = '0;
    logic [1:0]  cur_rresp = '0, cur_bresp = '0;
    logic r_pend = 0, b_pend = 0, aw_seen = 0, w_seen = 0, busy = 0, rst_edge = 1;
    logic ar_hs = 0, r_hs = 0, aw_hs = 0, w_hs = 0, b_hs = 0, m_hs = 0;
    exp_t ex = '0;

    mem_stage_lsu #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .addrE(addrE),
        .wdataE(wdataE), .memrdE(memrdE), .memwrE(memwrE), .funct3E(funct3E),
        .m_valid(m_valid), .m_ready(m_ready), .mdataM(mdataM), .errM(errM),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic finish_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    // Outcome of one instruction from the architectural rules alone.
    function automatic exp_t model(input logic rd, input logic wr, input logic [2:0] f3,
                                   input logic [31:0] a, input logic [31:0] wd,
                                   input logic [31:0] rdat, input logic [1:0] rr, input logic [1:0] br);
        exp_t e;
        int sz, off;
        longint v;
        e = '0;
        off = int'(a % 4);
        sz = 1 << f3[1:0];
        if (!rd && !wr) return e;
        if ((rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) || (!rd && f3 > 3'd2) || (a % sz != 0)) begin
            e.err = 1'b1;
            return e;
        end
        if (rd) begin
            e.kind = 2'd1;
            e.err = rr != 2'b00;
            v = (longint'(rdat) >> (8 * off)) & ((longint'(1) << (8 * sz)) - 1);
            if (f3 < 3'd2 && v >= (longint'(1) << (8 * sz - 1))) v = v - (longint'(1) << (8 * sz));
            e.mdata = e.err ? 32'd0 : 32'(v);
        end else begin
            e.kind = 2'd2;
            e.err = br != 2'b00;
            e.wd = sz == 1 ? 32'(wd[7:0]) * 32'h01010101 : sz == 2 ? 32'(wd[15:0]) * 32'h00010001 : wd;
            e.ws = 4'(((1 << sz) - 1) << off);
        end
        return e;
    endfunction

    // AXI slave: readies/valids set on negedge, handshakes recorded just before posedge.
    initial begin
        forever begin
            @(negedge clk);
            arready = arvalid && ar_cnt >= ar_dly;
            awready = awvalid && aw_cnt >= aw_dly;
            wready  = wvalid && w_cnt >= w_dly;
            rvalid  = r_pend && r_cnt >= r_dly;
            rdata   = rvalid ? cur_rdata : $urandom;
            rresp   = rvalid ? cur_rresp : 2'($urandom);
            bvalid  = b_pend && b_cnt >= b_dly;
            bresp   = bvalid ? cur_bresp : 2'($urandom);
            #4;
            rst_edge = rst;
            ar_hs = arvalid && arready; r_hs = rvalid && rready;
            aw_hs = awvalid && awready; w_hs = wvalid && wready;
            b_hs = bvalid && bready; m_hs = m_valid && m_ready;
            if (rst) begin
                r_pend = 0; b_pend = 0; aw_seen = 0; w_seen = 0;
                ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
            end else begin
                ar_cnt = ar_hs ? 0 : arvalid ? ar_cnt + 1 : ar_cnt;
                aw_cnt = aw_hs ? 0 : awvalid ? aw_cnt + 1 : aw_cnt;
                w_cnt  = w_hs ? 0 : wvalid ? w_cnt + 1 : w_cnt;
                if (r_pend && !rvalid) r_cnt++;
                if (b_pend && !bvalid) b_cnt++;
                if (r_hs) r_pend = 0;
                if (b_hs) b_pend = 0;
                if (ar_hs) begin r_pend = 1; r_cnt = 0; end
                aw_seen = aw_seen | aw_hs;
                w_seen = w_seen | w_hs;
                if (aw_seen && w_seen) begin b_pend = 1; b_cnt = 0; aw_seen = 0; w_seen = 0; end
                if (ar_hs) n_ar++;
                if (r_hs) n_r++;
                if (aw_hs) n_aw++;
                if (w_hs) n_w++;
                if (b_hs) n_b++;
            end
        end
    end

    // Every-cycle compare against the model and the AXI stability rules.
    logic p_arv = 0, p_awv = 0, p_wv = 0, p_mv = 0, p_br = 0, p_err = 0;
    logic [31:0] p_araddr = 0, p_awaddr = 0, p_wdata = 0, p_md = 0;
    logic [3:0] p_ws = 0;
    always @(negedge clk) begin
        if (!rst) begin
            chk("s_ready", s_ready, !busy);
            if (m_valid) begin
                chk("m_valid_busy", busy, 1);
                chk("mdataM", mdataM, ex.mdata);
                chk("errM", errM, ex.err);
            end
            if (arvalid) begin
                chk("arvalid_kind", busy && ex.kind == 2'd1, 1);
                chk("araddr", araddr, cur_addr);
            end
            if (rready) chk("rready_kind", busy && ex.kind == 2'd1, 1);
            if (awvalid) begin
                chk("awvalid_kind", busy && ex.kind == 2'd2, 1);
                chk("awaddr", awaddr, cur_addr);
            end
            if (wvalid) begin
                chk("wvalid_kind", busy && ex.kind == 2'd2, 1);
                chk("wdata", wdata, ex.wd);
                chk("wstrb", wstrb, ex.ws);
            end
            if (bready) chk("bready_kind", busy && ex.kind == 2'd2, 1);
            if (!rst_edge) begin
                if (p_arv && !ar_hs) begin chk("ar_hold", arvalid, 1); chk("araddr_hold", araddr, p_araddr); end
                if (p_awv && !aw_hs) begin chk("aw_hold", awvalid, 1); chk("awaddr_hold", awaddr, p_awaddr); end
                if (p_wv && !w_hs) begin
                    chk("w_hold", wvalid, 1); chk("wdata_hold", wdata, p_wdata); chk("wstrb_hold", wstrb, p_ws);
                end
                if (p_br && !b_hs) chk("bready_hold", bready, 1);
                if (p_mv && !m_hs) begin
                    chk("m_hold", m_valid, 1); chk("mdata_hold", mdataM, p_md); chk("err_hold", errM, p_err);
                end
            end
            p_arv = arvalid; p_araddr = araddr; p_awv = awvalid; p_awaddr = awaddr;
            p_wv = wvalid; p_wdata = wdata; p_ws = wstrb; p_br = bready;
            p_mv = m_valid; p_md = mdataM; p_err = errM;
        end
    end

    task automatic start(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rdat, input logic [1:0] rr,
                         input logic [1:0] br, input int dar, input int daw, input int dw,
                         input int dr, input int db);
        @(negedge clk);
        ar_dly = dar; aw_dly = daw; w_dly = dw; r_dly = dr; b_dly = db;
        cur_rdata = rdat; cur_rresp = rr; cur_bresp = br; cur_addr = a;
        ex = model(rd, wr, f3, a, wd, rdat, rr, br);
        addrE = a; wdataE = wd; memrdE = rd; memwrE = wr; funct3E = f3; s_valid = 1'b1;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        busy = 1'b1;
        n_ar = 0; n_r = 0; n_aw = 0; n_w = 0; n_b = 0;
    endtask

    task automatic txn(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rdat, input logic [1:0] rr,
                       input logic [1:0] br, input int dar, input int daw, input int dw,
                       input int dr, input int db, input int hold,
                       output logic [31:0] md, output logic er);
        int lat;
        logic seen;
        start(rd, wr, f3, a, wd, rdat, rr, br, dar, daw, dw, dr, db);
        lat = 0;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            lat++;
            seen = m_valid;
        end
        if (!seen) begin
            chk("m_valid_timeout", 0, 1);
            finish_run();
        end
        md = mdataM;
        er = errM;
        if ((dar | daw | dw | dr | db) == 0) chk("latency", lat, ex.kind == 2'd0 ? 1 : 3);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("bp_s_ready", s_ready, 0);
            chk("bp_mdata", mdataM, md);
        end
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        busy = 1'b0;
        chk("n_ar", n_ar, ex.kind == 2'd1);
        chk("n_r", n_r, ex.kind == 2'd1);
        chk("n_aw", n_aw, ex.kind == 2'd2);
        chk("n_w", n_w, ex.kind == 2'd2);
        chk("n_b", n_b, ex.kind == 2'd2);
    endtask

    logic [2:0] ld_codes[5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    initial begin
        logic [31:0] md, a;
        logic er, rd, wr, seen;
        logic [2:0] f3;
        logic [1:0] rr, br;
        int k, d[5];
        repeat (3) @(negedge clk);
        chk("rst_s_ready", s_ready, 1);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_valids", {arvalid, awvalid, wvalid, rready, bready}, 0);
        chk("rst_mdata", mdataM, 0);
        chk("rst_err", errM, 0);
        chk("rst_wstrb", wstrb, 0);
        chk("rst_addr", araddr | awaddr | wdata, 0);
        rst = 1'b0;

        txn(0, 0, 3'd2, 32'h1234_5677, 32'hdead_beef, 0, 0, 0, 0, 0, 0, 0, 0, 0, md, er);
        chk("nonmem_md", md, 0); chk("nonmem_err", er, 0);
        txn(1, 0, 3'd0, 32'h8000_0003, 0, 32'h80FF_0000, 0, 0, 0, 0, 0, 0, 0, 0, md, er);
        chk("lb_md", md, 32'hFFFF_FF80);
        txn(1, 0, 3'd4, 32'h8000_0003, 0, 32'h80FF_0000, 0, 0, 1, 0, 0, 2, 0, 0, md, er);
        chk("lbu_md", md, 32'h0000_0080);
        txn(1, 0, 3'd1, 32'h8000_0002, 0, 32'h80FF_0000, 0, 0, 0, 0, 0, 0, 0, 0, md, er);
        chk("lh_md", md, 32'hFFFF_80FF);
        txn(0, 1, 3'd1, 32'h8000_0002, 32'h1234_ABCD, 0, 0, 0, 0, 2, 0, 0, 1, 0, md, er);
        chk("sh_wd_model", ex.wd, 32'hABCD_ABCD);
        chk("sh_ws_model", ex.ws, 4'b1100);
        chk("sh_err", er, 0);
        txn(1, 0, 3'd2, 32'h8000_0001, 0, 32'h5555_5555, 0, 0, 0, 0, 0, 0, 0, 0, md, er);
        chk("lw_mis_err", er, 1); chk("lw_mis_md", md, 0);
        txn(1, 0, 3'd2, 32'h8000_0004, 0, 32'h5555_5555, 2'b10, 0, 0, 0, 0, 0, 0, 0, md, er);
        chk("slverr_err", er, 1); chk("slverr_md", md, 0);
        txn(1, 0, 3'd2, 32'h8000_0008, 0, 32'hCAFE_F00D, 0, 0, 0, 0, 0, 0, 0, 5, md, er);
        chk("bp_md", md, 32'hCAFE_F00D);

        start(1, 0, 3'd2, 32'h8000_0010, 0, 32'h0BAD_0BAD, 0, 0, 0, 0, 0, 8, 0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = rready;
        end
        chk("reach_rd_data", seen, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        busy = 1'b0;
        chk("mid_rst_ar_r_m", {arvalid, rready, m_valid}, 0);
        chk("mid_rst_s_ready", s_ready, 1);
        txn(1, 0, 3'd5, 32'h8000_0012, 0, 32'hF00D_8001, 0, 0, 0, 0, 0, 0, 0, 0, md, er);
        chk("post_rst_lhu", md, 32'h0000_F00D);

        for (int i = 0; i < 200; i++) begin
            k = $urandom_range(0, 9);
            rd = k < 4 || k == 9;
            wr = (k >= 4 && k < 8) || k == 9;
            f3 = $urandom_range(0, 9) < 8 ? (rd ? ld_codes[$urandom_range(0, 4)] : 3'($urandom_range(0, 2))) : 3'($urandom);
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << f3[1:0]) - 1);
            foreach (d[j]) d[j] = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) foreach (d[j]) d[j] = 0;
            rr = $urandom_range(0, 7) == 0 ? 2'($urandom_range(1, 3)) : 2'b00;
            br = $urandom_range(0, 7) == 0 ? 2'($urandom_range(1, 3)) : 2'b00;
            txn(rd, wr, f3, a, $urandom, $urandom, rr, br, d[0], d[1], d[2], d[3], d[4],
                $urandom_range(0, 2), md, er);
        end
        repeat (2) @(negedge clk);
        finish_run();
    end

    initial begin
        #500000;
        chk("global_timeout", 0, 1);
        finish_run();
    end
endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-access stage of the multi-cycle/pipelined core; sits between the E→M stage bus and the M→W stage bus.
- Accepts one instruction per handshake from upstream and performs its load or store over an AXI4-Lite master port.
- Produces the aligned and extended load data (mdataM) plus an access-error flag, then offers them downstream with valid/ready.
- Non-memory instructions pass through with a fixed one-cycle bubble.

Parameters:
ADDR_W, 32, byte-address width of the AXI4-Lite address channels.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
s_valid  in  1  upstream instruction valid
s_ready  out  1  block can accept an instruction
addrE  in  ADDR_W  effective address (ALU result)
wdataE  in  32  store data (rs2 value)
memrdE  in  1  instruction is a load
memwrE  in  1  instruction is a store
funct3E  in  3  access size/sign code
m_valid  out  1  result valid toward the W stage bus
m_ready  in  1  W stage bus can accept
mdataM  out  32  extended load data; 0 for non-loads
errM  out  1  misaligned access, illegal funct3, or non-OKAY response
araddr/arvalid/arready  out/out/in  ADDR_W/1/1  AXI read address channel
rdata/rresp/rvalid/rready  in/in/in/out  32/2/1/1  AXI read data channel
awaddr/awvalid/awready  out/out/in  ADDR_W/1/1  AXI write address channel
wdata/wstrb/wvalid/wready  out/out/out/in  32/4/1/1  AXI write data channel
bresp/bvalid/bready  in/in/out  2/1/1  AXI write response channel

Behaviour:
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- Reset: state=IDLE; s_ready=1; all other outputs=0; aw_done=w_done=0; latched addr/data/op=0. Reset mid-transaction abandons the transaction; the AXI slave is reset by the same rst.
- s_ready = (state==IDLE). m_valid = (state==DONE). No combinational path from any input to s_ready or m_valid.
- On s_valid&s_ready: latch addrE, wdataE, memrdE, memwrE, funct3E. Compute the error condition from the latched fields:
  - funct3 illegal for the op. Loads allow 000/001/010/100/101; stores allow 000/001/010.
  - Misaligned access: halfword with addr[0]=1, or word with addr[1:0]≠0.
- Transitions out of IDLE on accept:
  - Error condition → DONE with errM=1, mdataM=0, no AXI traffic.
  - memrdE → RD_ADDR. memrdE takes priority if memrdE and memwrE are both set.
  - memwrE → WR_REQ.
  - Otherwise → DONE with errM=0, mdataM=0.
- RD_ADDR: arvalid=1, araddr=latched addr. On arready → RD_DATA.
- RD_DATA: rready=1. On rvalid:
  - Capture data: byte/half selected by addr[1:0], sign-extended for 000/001, zero-extended for 100/101.
  - errM=(rresp≠0); mdataM=0 if errM.
  - → DONE.
- WR_REQ: awvalid=!aw_done and wvalid=!w_done.
  - awaddr=latched addr.
  - wdata: replicated byte {4{b}} for SB, half {2{h}} for SH, word for SW.
  - wstrb: 0001<<addr[1:0] for SB, 0011<<addr[1:0] for SH, 1111 for SW.
  - Set aw_done on awvalid&awready and w_done on wvalid&wready. The two handshakes may complete in either order or in the same cycle.
  - When both are done (including the same cycle): clear both flags → WR_RESP.
- WR_RESP: bready=1. On bvalid: errM=(bresp≠0), mdataM=0 → DONE.
- DONE: hold mdataM/errM stable. On m_ready → IDLE.
- Latency with zero-wait slave: non-mem accept→m_valid 1 cycle; load 3 cycles; store 3 cycles.
- AXI valids never drop before their handshake; addresses and data are stable while valid.

Decomposition:
- Shared package: funct3 codes (LB/LH/LW/LBU/LHU/SB/SH/SW), state encodings, AXI RESP_OKAY=2'b00.
- One sub-module, lsu_data_align (combinational): store wdata/wstrb generation, load byte-lane extraction and extension, and misalign/illegal detection.

Test Plan:
- Non-mem op (memrd=memwr=0), m_ready=1 → m_valid one cycle after accept; mdataM=0, errM=0; no AXI valids.
- LB addr=0x80000003, slave rdata=0x80FF_0000 → mdataM=0xFFFFFF80. LBU at same address → 0x00000080. LH addr=0x80000002 → 0xFFFF80FF.
- SH addr=0x80000002, wdataE=0x1234ABCD → wdata=0xABCDABCD, wstrb=1100. Slave asserts wready 2 cycles before awready → one WR_RESP entry; bready held until bvalid.
- LW addr=0x80000001 → errM=1, mdataM=0, no arvalid. Load with rresp=2'b10 → errM=1.
- Backpressure: m_ready=0 for 5 cycles in DONE → s_ready=0 and mdataM stable throughout; m_ready=1 → IDLE next cycle.
- rst asserted while in RD_DATA → next cycle arvalid=rready=m_valid=0, s_ready=1; new load after reset completes normally.
